seq_lock: RTL
=============

SEQ_LOCK -- requirements
Module: seq_lock

Interface
REQ-001 SHALL have parameter NUM_SW, default 9: number of entry switches.
REQ-002 SHALL have parameter CODE_LEN, default 4: digits per code (2..8).
REQ-003 SHALL have parameter DEFAULT_CODE, default {4'd5,4'd6,4'd8,4'd7}: reset code, digit 0 in LSBs, DW=clog2(NUM_SW) bits per digit.
REQ-004 SHALL have parameter HOLD_CYCLES, default 50_000_000: result display time in clk cycles.
REQ-005 SHALL have parameter MAX_FAILS, default 3: consecutive failed entries before lockout.
REQ-006 SHALL have parameter LOCKOUT_CYCLES, default 500_000_000: lockout duration in clk cycles.
REQ-007 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port sw, input, NUM_SW: asynchronous entry switches.
REQ-010 SHALL have port prog, input, 1: asynchronous level, requests code programming.
REQ-011 SHALL have ports hex0..hex4, output, 7 each: active-low seven-segment, registered.
REQ-012 SHALL have port progress, output, CODE_LEN: thermometer count of accepted digits.
REQ-013 SHALL have ports unlocked, output, 1 (high in OK_HOLD after entry), and locked_out, output, 1 (high in LOCKOUT).

Function
REQ-014 sw and prog SHALL pass a 2-flop synchroniser; a digit event is a 0->1 transition of a synchronised sw bit.
REQ-015 An event with exactly one rising bit SHALL be a digit equal to that bit index; more than one rising bit in one cycle SHALL be a wrong digit.
REQ-016 States SHALL be IDLE, ENTRY, PROG, OK_HOLD, ERR_HOLD, LOCKOUT.
REQ-017 IDLE: synchronised prog=1 -> PROG (priority over digits); correct digit 0 -> ENTRY with idx=1; wrong digit -> ERR_HOLD.
REQ-018 ENTRY: digit == code[idx] -> idx+1; when idx reaches CODE_LEN -> OK_HOLD; wrong digit -> ERR_HOLD; no event -> stay.
REQ-019 PROG: each single-bit event writes a shadow code[idx]; after CODE_LEN digits the shadow SHALL commit to the active code and go to OK_HOLD; a multi-bit event -> ERR_HOLD, active code unchanged; prog falling before completion -> IDLE, active code unchanged.
REQ-020 OK_HOLD and ERR_HOLD SHALL last exactly HOLD_CYCLES cycles, then return to IDLE; all events ignored.
REQ-021 Failed entry (ERR_HOLD from IDLE/ENTRY) SHALL increment fail count; reaching MAX_FAILS SHALL go to LOCKOUT instead of ERR_HOLD.
REQ-022 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, ignoring events and prog, then go to IDLE and clear fail count.
REQ-023 Successful entry SHALL clear fail count; programming errors SHALL NOT count as failures.
REQ-024 State SHALL change on the clk edge after the cycle in which a synchronised event is detected; hex outputs SHALL lag state by one cycle.
REQ-025 Displays: IDLE/ENTRY blank; PROG "ProG"; OK_HOLD "donE" on hex3..hex0; ERR_HOLD "Error" on hex4..hex0; LOCKOUT "LOCd"; unused digits blank (7'h7F).
REQ-026 progress SHALL show idx in ENTRY/PROG, all ones in OK_HOLD, and zero otherwise.

Reset
REQ-027 reset SHALL immediately force IDLE, idx=0, fail count=0, timers=0, active code=DEFAULT_CODE, synchroniser and edge flops=0, hex0..hex4=7'h7F, progress=0, unlocked=0, locked_out=0.
REQ-028 reset during any state, including mid-PROG or LOCKOUT, SHALL discard the shadow code and restore DEFAULT_CODE.

Structure
REQ-029 Package seq_lock_pkg SHALL hold the state enum and the seven-segment glyph constants (blank, d, o, n, E, r, P, G, L, O, C).
REQ-030 Sub-module sw_edge_sync SHALL implement the synchroniser and rising-edge detection, parametrised by width.
REQ-031 A single down-counter, sized for max(HOLD_CYCLES, LOCKOUT_CYCLES), SHALL serve both hold and lockout.

Verification (HOLD_CYCLES=4, LOCKOUT_CYCLES=8, MAX_FAILS=3)
REQ-032 Pulse sw[7], sw[8], sw[6], sw[5] in turn -> progress 1,3,7,15; "donE" and unlocked=1 for 4 cycles; then IDLE.
REQ-033 Pulse sw[7], then sw[2] -> "Error" for 4 cycles; fail count 1; progress 0.
REQ-034 Three wrong first digits -> ERR_HOLD, ERR_HOLD, then LOCKOUT for 8 cycles with sw pulses ignored; then a correct code -> "donE".
REQ-035 prog=1, pulse sw[1], sw[2], sw[3], sw[4] -> "donE"; then 1-2-3-4 unlocks and 7-8-6-5 errors; apply reset -> 7-8-6-5 unlocks.
REQ-036 sw[7] and sw[3] rising in the same cycle while in IDLE -> ERR_HOLD.
REQ-037 Assert reset mid-ENTRY (progress=3) -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/seq_lock_pkg.sv
// Shared types and seven-segment glyphs for the sequential code lock.
// Glyphs are active-low, bit 0 = segment a ... bit 6 = segment g.
package seq_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_PROG,
    ST_OK_HOLD,
    ST_ERR_HOLD,
    ST_LOCKOUT
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_O_LC  = 7'h23;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_O_UC  = 7'h40;
  localparam logic [6:0] SEG_C     = 7'h46;

endpackage

// File: rtl/sw_edge_sync.sv
// Two-flop synchroniser with rising-edge detect on the synchronised level.
module sw_edge_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/seq_lock.sv
// Switch-sequence code lock with code programming, result hold and fail lockout.
// state     | meaning
// IDLE      | waiting for first digit or prog request
// ENTRY     | collecting digits, idx = digits accepted so far
// PROG      | collecting a new code into the shadow register
// OK_HOLD   | "donE" shown for HOLD_CYCLES
// ERR_HOLD  | "Error" shown for HOLD_CYCLES
// LOCKOUT   | "LOCd" shown for LOCKOUT_CYCLES, inputs ignored
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int unsigned NUM_SW         = 9,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [CODE_LEN*$clog2(NUM_SW)-1:0] DEFAULT_CODE = {4'd5, 4'd6, 4'd8, 4'd7},
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SW-1:0]   sw,
  input  logic                prog,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [6:0]          hex3,
  output logic [6:0]          hex4,
  output logic [CODE_LEN-1:0] progress,
  output logic                unlocked,
  output logic                locked_out
);

  localparam int unsigned DW   = $clog2(NUM_SW);
  localparam int unsigned CW   = CODE_LEN * DW;
  localparam int unsigned IW   = $clog2(CODE_LEN + 1);
  localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
  localparam int unsigned MAXC = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = $clog2(MAXC + 1);

  logic [NUM_SW:0] sync_all, rise_all;
  logic [NUM_SW-1:0] rise_sw;
  logic prog_s, evt, one_hot, match, unused_sync;
  logic [DW-1:0] digit;

  sw_edge_sync #(.W(NUM_SW + 1)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i ({prog, sw}),
    .sync_o  (sync_all),
    .rise_o  (rise_all)
  );

  assign rise_sw     = rise_all[NUM_SW-1:0];
  assign prog_s      = sync_all[NUM_SW];
  assign unused_sync = ^{sync_all[NUM_SW-1:0], rise_all[NUM_SW]};

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CW-1:0]       code_q, code_d, shadow_q, shadow_d;
  logic                unl_q, unl_d;
  logic [4:0][6:0]     hex_q, hex_d;

  always_comb begin
    digit = '0;
    for (int i = 0; i < NUM_SW; i++)
      if (rise_sw[i]) digit = DW'(i);
  end

  assign evt     = |rise_sw;
  assign one_hot = $onehot(rise_sw);
  assign match   = one_hot && (digit == code_q[idx_q*DW +: DW]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
      unl_q    <= 1'b0;
      hex_q    <= {5{SEG_BLANK}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      unl_q    <= unl_d;
      hex_q    <= hex_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    unl_d    = unl_q;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (state_q == ST_IDLE && prog_s) begin
          state_d = ST_PROG;
          idx_d   = '0;
        end else if (evt) begin
          if (match && idx_q == IW'(CODE_LEN - 1)) begin
            state_d = ST_OK_HOLD;
            timer_d = TW'(HOLD_CYCLES - 1);
            idx_d   = '0;
            fail_d  = '0;
            unl_d   = 1'b1;
          end else if (match) begin
            state_d = ST_ENTRY;
            idx_d   = idx_q + IW'(1);
          end else if (fail_q >= FW'(MAX_FAILS - 1)) begin
            state_d = ST_LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
            idx_d   = '0;
          end else begin
            state_d = ST_ERR_HOLD;
            timer_d = TW'(HOLD_CYCLES - 1);
            idx_d   = '0;
            fail_d  = fail_q + FW'(1);
          end
        end
      end
      ST_PROG: begin
        if (!prog_s) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (evt && !one_hot) begin
          state_d = ST_ERR_HOLD;
          timer_d = TW'(HOLD_CYCLES - 1);
          idx_d   = '0;
        end else if (evt) begin
          shadow_d[idx_q*DW +: DW] = digit;
          if (idx_q == IW'(CODE_LEN - 1)) begin
            code_d  = shadow_d;
            state_d = ST_OK_HOLD;
            timer_d = TW'(HOLD_CYCLES - 1);
            idx_d   = '0;
            unl_d   = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_OK_HOLD, ST_ERR_HOLD: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          unl_d   = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hex_d      = {5{SEG_BLANK}};
    progress   = '0;
    unlocked   = 1'b0;
    locked_out = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        for (int i = 0; i < CODE_LEN; i++) progress[i] = (IW'(i) < idx_q);
      end
      ST_PROG: begin
        for (int i = 0; i < CODE_LEN; i++) progress[i] = (IW'(i) < idx_q);
        hex_d[3:0] = {SEG_P, SEG_R, SEG_O_LC, SEG_G};
      end
      ST_OK_HOLD: begin
        progress   = '1;
        unlocked   = unl_q;
        hex_d[3:0] = {SEG_D, SEG_O_LC, SEG_N, SEG_E};
      end
      ST_ERR_HOLD: hex_d = {SEG_E, SEG_R, SEG_R, SEG_O_LC, SEG_R};
      ST_LOCKOUT: begin
        locked_out = 1'b1;
        hex_d[3:0] = {SEG_L, SEG_O_UC, SEG_C, SEG_D};
      end
      default: ;
    endcase
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];

endmodule
